// File: rtl/conv_pkg.sv
// Shared types for the convolution sequencer: FSM state encoding,
// MAC data width and the MAC control-strobe bundle.
`timescale 1ns/1ps
package conv_pkg;

  localparam int CONV_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    LAST = 3'd2,
    SAT  = 3'd3,
    CAPT = 3'd4,
    OUT  = 3'd5,
    FIN  = 3'd6
  } conv_seq_state_t;

  typedef struct packed {
    logic clken;
    logic s_convout;
    logic en_sat;
    logic en_mult_r;
  } mac_ctrl_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Tap / output-index counters and operand address generation.
// The signal base of the current output is kept as a running sum
// (sig_base + out_idx*sig_stride) so no multiplier is required.
`timescale 1ns/1ps
module conv_addr_gen #(
  parameter int KERNEL = 9,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              next_out,
  input  logic [ADDR_W-1:0] sig_base,
  input  logic [ADDR_W-1:0] sig_stride,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic              last_tap,
  output logic [CNT_W-1:0]  out_idx,
  output logic [ADDR_W-1:0] sig_addr,
  output logic [ADDR_W-1:0] wgt_addr
);

  localparam int TAP_W = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL - 1);

  logic [TAP_W-1:0]  tap_reg;
  logic [CNT_W-1:0]  out_idx_reg;
  logic [ADDR_W-1:0] sig_acc_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [ADDR_W-1:0] wgt_base_reg;

  // Latch job parameters at start, advance tap within an output and
  // the signal base accumulator between outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_reg      <= '0;
      out_idx_reg  <= '0;
      sig_acc_reg  <= '0;
      stride_reg   <= '0;
      wgt_base_reg <= '0;
    end else if (load) begin
      tap_reg      <= '0;
      out_idx_reg  <= '0;
      sig_acc_reg  <= sig_base;
      stride_reg   <= sig_stride;
      wgt_base_reg <= wgt_base;
    end else if (next_out) begin
      tap_reg     <= '0;
      out_idx_reg <= out_idx_reg + CNT_W'(1);
      sig_acc_reg <= sig_acc_reg + stride_reg;
    end else if (step && !last_tap) begin
      tap_reg <= tap_reg + TAP_W'(1);
    end
  end

  assign last_tap = (tap_reg == TAP_LAST);
  assign out_idx  = out_idx_reg;

  // Addresses are only meaningful while reading; hold them at zero otherwise.
  assign sig_addr = step ? (sig_acc_reg + ADDR_W'(tap_reg)) : '0;
  assign wgt_addr = step ? (wgt_base_reg + ADDR_W'(tap_reg)) : '0;

endmodule

// File: rtl/conv_sequencer.sv
// Job sequencer for the convolution MAC: issues operand reads, drives
// the MAC strobes, captures each saturated result and hands it out on
// a valid/ready port.
`timescale 1ns/1ps
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int KERNEL = 9,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [CNT_W-1:0]              n_out,
  input  logic [ADDR_W-1:0]             sig_base,
  input  logic [ADDR_W-1:0]             sig_stride,
  input  logic [ADDR_W-1:0]             wgt_base,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             sig_addr,
  output logic [ADDR_W-1:0]             wgt_addr,
  output logic                          mem_rd,
  output logic                          clken,
  output logic                          s_convout,
  output logic                          en_sat,
  output logic                          en_mult_r,
  input  logic signed [CONV_DATA_W-1:0] convout,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic signed [CONV_DATA_W-1:0] res_data,
  output logic [CNT_W-1:0]              res_idx
);

  conv_seq_state_t state_reg, state_next;

  logic [CNT_W-1:0]              n_out_reg;
  logic signed [CONV_DATA_W-1:0] res_data_reg;
  logic [CNT_W-1:0]              res_idx_reg;
  logic                          clken_reg;
  logic                          s_convout_reg;

  logic             load;
  logic             step;
  logic             next_out;
  logic             last_tap;
  logic             last_out;
  logic [CNT_W-1:0] out_idx;
  mac_ctrl_t        mac;

  conv_addr_gen #(
    .KERNEL (KERNEL),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .step       (step),
    .next_out   (next_out),
    .sig_base   (sig_base),
    .sig_stride (sig_stride),
    .wgt_base   (wgt_base),
    .last_tap   (last_tap),
    .out_idx    (out_idx),
    .sig_addr   (sig_addr),
    .wgt_addr   (wgt_addr)
  );

  assign last_out = ((out_idx + CNT_W'(1)) == n_out_reg);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and per-state outputs.
  always_comb begin
    state_next    = state_reg;
    load          = 1'b0;
    step          = 1'b0;
    next_out      = 1'b0;
    busy          = (state_reg != IDLE);
    done          = 1'b0;
    mem_rd        = 1'b0;
    res_valid     = 1'b0;
    mac           = '0;
    mac.clken     = clken_reg;
    mac.s_convout = s_convout_reg;
    mac.en_mult_r = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (n_out == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        step   = 1'b1;
        mem_rd = 1'b1;
        if (last_tap) begin
          state_next = LAST;
        end
      end
      LAST: begin
        state_next = SAT;
      end
      SAT: begin
        mac.en_sat = 1'b1;
        state_next = CAPT;
      end
      CAPT: begin
        mac.en_sat = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          next_out   = 1'b1;
          state_next = last_out ? FIN : RUN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Delay the read strobe by the memory latency so clken / s_convout
  // line up with the operand data arriving at the MAC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken_reg     <= 1'b0;
      s_convout_reg <= 1'b0;
    end else begin
      clken_reg     <= step;
      s_convout_reg <= step && last_tap;
    end
  end

  // Job length is frozen at start so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_out_reg <= '0;
    end else if (load) begin
      n_out_reg <= n_out;
    end
  end

  // Capture the saturated MAC result; held stable through OUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_data_reg <= '0;
      res_idx_reg  <= '0;
    end else if (state_reg == CAPT) begin
      res_data_reg <= convout;
      res_idx_reg  <= out_idx;
    end
  end

  assign clken     = mac.clken;
  assign s_convout = mac.s_convout;
  assign en_sat    = mac.en_sat;
  assign en_mult_r = mac.en_mult_r;
  assign res_data  = res_data_reg;
  assign res_idx   = res_idx_reg;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: randomized jobs compared
// cycle by cycle against an offset-based timeline model, plus a
// directed KERNEL=1 run on a second instance.
`timescale 1ns/1ps
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int K  = 9;
  localparam int AW = 12;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic reset_n;

  // Main instance (KERNEL=9)
  logic          start;
  logic [CW-1:0] n_out;
  logic [AW-1:0] sig_base, sig_stride, wgt_base;
  logic          busy, done, mem_rd, clken, s_convout, en_sat, en_mult_r;
  logic [AW-1:0] sig_addr, wgt_addr;
  logic [7:0]    convout, res_data;
  logic          res_valid, res_ready;
  logic [CW-1:0] res_idx;

  // Second instance (KERNEL=1)
  logic          start_b;
  logic [CW-1:0] n_out_b;
  logic [AW-1:0] sig_base_b, sig_stride_b, wgt_base_b;
  logic          busy_b, done_b, mem_rd_b, clken_b, s_convout_b, en_sat_b, en_mult_r_b;
  logic [AW-1:0] sig_addr_b, wgt_addr_b;
  logic [7:0]    convout_b, res_data_b;
  logic          res_valid_b, res_ready_b;
  logic [CW-1:0] res_idx_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  conv_sequencer #(.KERNEL(K), .ADDR_W(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_out(n_out),
    .sig_base(sig_base), .sig_stride(sig_stride), .wgt_base(wgt_base),
    .busy(busy), .done(done), .sig_addr(sig_addr), .wgt_addr(wgt_addr),
    .mem_rd(mem_rd), .clken(clken), .s_convout(s_convout), .en_sat(en_sat),
    .en_mult_r(en_mult_r), .convout(convout), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_idx(res_idx)
  );

  conv_sequencer #(.KERNEL(1), .ADDR_W(AW), .CNT_W(CW)) u_dut_k1 (
    .clk(clk), .reset_n(reset_n), .start(start_b), .n_out(n_out_b),
    .sig_base(sig_base_b), .sig_stride(sig_stride_b), .wgt_base(wgt_base_b),
    .busy(busy_b), .done(done_b), .sig_addr(sig_addr_b), .wgt_addr(wgt_addr_b),
    .mem_rd(mem_rd_b), .clken(clken_b), .s_convout(s_convout_b), .en_sat(en_sat_b),
    .en_mult_r(en_mult_r_b), .convout(convout_b), .res_valid(res_valid_b),
    .res_ready(res_ready_b), .res_data(res_data_b), .res_idx(res_idx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset();
    check("rst busy",      32'(busy),      32'd0);
    check("rst done",      32'(done),      32'd0);
    check("rst mem_rd",    32'(mem_rd),    32'd0);
    check("rst clken",     32'(clken),     32'd0);
    check("rst s_convout", 32'(s_convout), 32'd0);
    check("rst en_sat",    32'(en_sat),    32'd0);
    check("rst en_mult_r", 32'(en_mult_r), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_data",  32'(res_data),  32'd0);
    check("rst res_idx",   32'(res_idx),   32'd0);
    check("rst sig_addr",  32'(sig_addr),  32'd0);
    check("rst wgt_addr",  32'(wgt_addr),  32'd0);
  endtask

  // Expected behaviour per cycle is derived from t, the number of cycles
  // since the first read of output o: reads at t<K, clken at 1..K,
  // s_convout at K, en_sat at K+1..K+2, result offered from K+3 on.
  // mode 0: ready always high, 1: random ready, 2: 5 stall cycles on output 0.
  task automatic run_job(input int n, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [AW-1:0] wbase, input int mode, input int abort_o);
    logic [7:0] data;
    int         t;
    int         stall;
    bit         handshake;
    @(negedge clk);
    start = 1'b1; n_out = CW'(n); sig_base = base; sig_stride = stride; wgt_base = wbase;
    @(posedge clk);
    for (int o = 0; o < n; o++) begin
      data      = 8'($urandom);
      t         = 0;
      stall     = 0;
      handshake = 1'b0;
      while (!handshake) begin
        @(negedge clk);
        // Inputs the DUT must ignore once the job is running.
        start      = 1'($urandom);
        n_out      = CW'($urandom);
        sig_base   = AW'($urandom);
        sig_stride = AW'($urandom);
        wgt_base   = AW'($urandom);
        convout    = (t == K + 2) ? data : 8'($urandom);
        if (o == abort_o && t == 3) begin
          reset_n = 1'b0;
          start   = 1'b0;
          #1;
          check_reset();
          @(negedge clk);
          reset_n = 1'b1;
          $display("job aborted by reset at output %0d", o);
          return;
        end
        check("busy",      32'(busy),      32'd1);
        check("en_mult_r", 32'(en_mult_r), 32'd1);
        check("done",      32'(done),      32'd0);
        check("mem_rd",    32'(mem_rd),    32'(t < K));
        if (t < K) begin
          check("sig_addr", 32'(sig_addr), 32'(AW'(base + o * stride + t)));
          check("wgt_addr", 32'(wgt_addr), 32'(AW'(wbase + t)));
        end
        check("clken",     32'(clken),     32'(t >= 1 && t <= K));
        check("s_convout", 32'(s_convout), 32'(t == K));
        check("en_sat",    32'(en_sat),    32'(t == K + 1 || t == K + 2));
        check("res_valid", 32'(res_valid), 32'(t >= K + 3));
        if (t >= K + 3) begin
          check("res_data", 32'(res_data), 32'(data));
          check("res_idx",  32'(res_idx),  32'(o));
        end
        case (mode)
          0:       res_ready = 1'b1;
          1:       res_ready = 1'($urandom_range(0, 1));
          default: res_ready = (o == 0 && stall < 5) ? 1'b0 : 1'b1;
        endcase
        if (t > K + 40) res_ready = 1'b1;
        if (t >= K + 3) begin
          if (res_ready) handshake = 1'b1;
          else stall++;
        end
        t++;
      end
      $display("result idx=%0d data=0x%02h stalls=%0d", o, data, stall);
    end
    @(negedge clk);
    start     = 1'b0;
    res_ready = 1'($urandom);
    check("fin done",      32'(done),      32'd1);
    check("fin busy",      32'(busy),      32'd1);
    check("fin mem_rd",    32'(mem_rd),    32'd0);
    check("fin res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("idle done",      32'(done),      32'd0);
    check("idle busy",      32'(busy),      32'd0);
    check("idle en_mult_r", 32'(en_mult_r), 32'd0);
    $display("job n_out=%0d complete", n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; n_out = '0; sig_base = '0; sig_stride = '0; wgt_base = '0;
    convout = '0; res_ready = 1'b0;
    start_b = 1'b0; n_out_b = '0; sig_base_b = '0; sig_stride_b = '0; wgt_base_b = '0;
    convout_b = '0; res_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    check_reset();
    reset_n = 1'b1;
    @(negedge clk);
    check_reset();

    run_job(1, 12'h010, 12'h004, 12'h100, 0, -1);
    run_job(3, 12'h040, 12'h004, 12'h200, 0, -1);
    run_job(2, 12'h080, 12'h003, 12'h000, 2, -1);
    run_job(0, 12'h123, 12'h001, 12'h456, 0, -1);
    run_job(2, 12'hFFE, 12'h001, 12'hFFD, 1, -1);
    run_job(3, 12'h100, 12'h010, 12'h050, 1, 1);
    check("post-abort busy", 32'(busy), 32'd0);
    run_job(2, 12'h200, 12'h008, 12'h020, 1, -1);
    for (int j = 0; j < 5; j++) begin
      run_job(int'($urandom_range(1, 4)), AW'($urandom), AW'($urandom), AW'($urandom), 1, -1);
    end

    // KERNEL=1: clken and s_convout coincide in the single LAST cycle.
    @(negedge clk);
    start_b = 1'b1; n_out_b = 10'd1; sig_base_b = 12'h020; sig_stride_b = 12'h000;
    wgt_base_b = 12'h300; convout_b = 8'h33; res_ready_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("k1 mem_rd",   32'(mem_rd_b),   32'd1);
    check("k1 sig_addr", 32'(sig_addr_b), 32'h020);
    check("k1 wgt_addr", 32'(wgt_addr_b), 32'h300);
    check("k1 clken0",   32'(clken_b),    32'd0);
    @(negedge clk);
    check("k1 clken",     32'(clken_b),     32'd1);
    check("k1 s_convout", 32'(s_convout_b), 32'd1);
    check("k1 mem_rd0",   32'(mem_rd_b),    32'd0);
    @(negedge clk);
    check("k1 en_sat sat", 32'(en_sat_b), 32'd1);
    @(negedge clk);
    check("k1 en_sat capt", 32'(en_sat_b), 32'd1);
    @(negedge clk);
    check("k1 res_valid", 32'(res_valid_b), 32'd1);
    check("k1 res_data",  32'(res_data_b),  32'h33);
    check("k1 res_idx",   32'(res_idx_b),   32'd0);
    $display("k1 result idx=%0d data=0x%02h", res_idx_b, res_data_b);
    @(negedge clk);
    check("k1 done", 32'(done_b), 32'd1);
    @(negedge clk);
    check("k1 busy", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control sequencer that drives the convolution MAC datapath for one job: it issues signal/weight memory reads, generates the MAC control strobes (`clken`, `s_convout`, `en_sat`, `en_mult_r`) and captures each saturated 8-bit `convout`. Each result is returned on a valid/ready output port. It sits between the layer controller (start/done) and the MAC plus its two operand memories (1-cycle read latency). It is the initiator of the MAC control interface, which only responds to the strobes.

## Interface
- `KERNEL`, default 9: taps per output (≥1).
- `ADDR_W`, default 12: signal/weight memory address width.
- `CNT_W`, default 10: width of output-count and output-index fields.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `n_out` in CNT_W: outputs in job; latched at start.
- `sig_base` in ADDR_W: first signal address; latched at start.
- `sig_stride` in ADDR_W: signal address step per output; latched at start.
- `wgt_base` in ADDR_W: first weight address; latched at start.
- `busy` out 1: high from accepted start until done.
- `done` out 1: 1-cycle pulse at job end.
- `sig_addr`, `wgt_addr` out ADDR_W: operand read addresses.
- `mem_rd` out 1: read strobe for both memories.
- `clken`, `s_convout`, `en_sat`, `en_mult_r` out 1: MAC controls.
- `convout` in 8 signed: MAC result.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 8 signed: captured `convout`.
- `res_idx` out CNT_W: output index of `res_data`.

## Operation
- States: IDLE, RUN, LAST, SAT, CAPT, OUT, FIN.
- IDLE: `start`=1 latches the inputs, clears `out_idx` and `tap`, and sets `busy`.
  - If `n_out`==0, go to FIN.
  - Otherwise go to RUN.
- RUN: one cycle per tap, `tap`=0..KERNEL-1.
  - Outputs: `mem_rd`=1, `sig_addr`=sig_base+out_idx*sig_stride+tap, `wgt_addr`=wgt_base+tap.
  - Addresses wrap modulo 2^ADDR_W.
  - After `tap`==KERNEL-1, go to LAST.
- `clken` is `mem_rd` delayed one cycle. `s_convout` is (`mem_rd` and `tap`==KERNEL-1) delayed one cycle. This aligns both strobes with the operand data returned by memory.
- LAST: one cycle; it carries the delayed strobes of the final tap. Go to SAT.
- SAT: `en_sat`=1. Go to CAPT.
- CAPT: `en_sat`=1. `res_data`<=`convout` and `res_idx`<=out_idx at the end of the cycle. Go to OUT.
- OUT: `res_valid`=1; `res_data` and `res_idx` are held stable.
  - On `res_valid`&&`res_ready`: out_idx++ and `tap`<=0.
  - If out_idx+1==n_out, go to FIN; otherwise go to RUN.
- FIN: `done`=1 for one cycle, `busy`=0 next cycle. Go to IDLE.
- `en_mult_r`=1 whenever `busy`, else 0.
- `start` while `busy` is ignored, and so are latched-input changes after start.

## Timing
- Reset (async assert, synchronous release) sets state=IDLE. All outputs are 0: `busy`, `done`, `mem_rd`, the MAC strobes, `res_valid`, `res_data`, `res_idx`, and both addresses.
- Reset asserted mid-job aborts the job immediately, with no `done` and no `res_valid`.
- Start accepted at cycle 0: the first RUN cycle is 1, first `clken` at cycle 2, LAST at KERNEL+1, SAT at KERNEL+2, CAPT at KERNEL+3, `res_valid` from KERNEL+4.
- With `res_ready` held at 1, each output takes KERNEL+4 cycles. `done` falls KERNEL+5 cycles after the final RUN start.
- The `res_valid` handshake follows AXI-style rules: once raised, `res_valid` stays high until accepted. `res_ready` may be asserted before `res_valid`.
- A `res_ready` stall holds the machine in OUT. No MAC strobes are driven during OUT.
- KERNEL=1: RUN lasts one cycle, and `clken` and `s_convout` are asserted in the same cycle (LAST).

## Structure
- Shared package `conv_pkg`: state enum type `conv_seq_state_t`, `CONV_DATA_W`=8, and the MAC control-bundle typedef (clken, s_convout, en_sat, en_mult_r).
- One natural sub-module: `conv_addr_gen`. It holds the tap and out_idx counters, the running signal-base accumulator (add sig_stride per output, so no multiplier is needed), and the address outputs. The FSM and strobe-delay flops stay in the top.

## Test plan
- KERNEL=9, n_out=1, sig_base=0x010, wgt_base=0x100: `sig_addr` steps 0x010..0x018 over cycles 1..9. `clken` is high in cycles 2..10 and `s_convout` only in cycle 10. `en_sat` is high in cycles 11–12. With a stub `convout`=0x5A, `res_data`=0x5A and `res_idx`=0. `done` pulses one cycle after the handshake.
- n_out=3, sig_stride=4, `res_ready`=1: `res_idx` goes 0,1,2 with outputs spaced 13 cycles apart. Output 2 reads signal addresses base+8..base+16.
- `res_ready` held low 5 cycles in OUT: `res_valid`, `res_data` and `res_idx` stay stable. No `mem_rd` or `clken` is issued until the handshake.
- n_out=0: `busy` lasts 1 cycle and `done` pulses. No `mem_rd` and no `res_valid`.
- sig_base=0xFFE, stride=1, KERNEL=4: addresses wrap as 0xFFE, 0xFFF, 0x000, 0x001.
- `reset_n` low during the RUN of output 1: all outputs are 0 in the same cycle and the state is IDLE. A new `start` after release runs a clean job with `res_idx` starting at 0.
